// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared types for the CPU cycle sequencer.
// Instruction lengths, microcode phases and sequencer states.
package cpu_cycle_sequencer_pkg;

    typedef enum logic [1:0] {
        CYCLE5  = 2'd0,
        CYCLE7  = 2'd1,
        CYCLE12 = 2'd2
    } instr_length;

    typedef enum logic [1:0] {
        CYCLE_NONE      = 2'd0,
        CYCLE_REG_FETCH = 2'd1,
        CYCLE_REG_WRITE = 2'd2
    } microcode_cycle;

    typedef enum logic [1:0] {
        SEQ_FETCH,
        SEQ_EXEC,
        SEQ_HALT,
        SEQ_INTERRUPT
    } seq_state;

    localparam logic [2:0] INTERRUPT_STEPS  = 3'd3;
    localparam logic [3:0] INTERRUPT_LENGTH = 4'd12;

    function automatic logic [3:0] cycle_count_int(input instr_length len);
        case (len)
            CYCLE7:  return 4'd7;
            CYCLE12: return 4'd12;
            default: return 4'd5;
        endcase
    endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_cycle_slot_decoder.sv
// Maps a cycle position and slot count to the microcode phase.
// Slots are REG_FETCH/REG_WRITE pairs starting at cycle 2.
module cycle_slot_decoder
    import cpu_cycle_sequencer_pkg::*;
(
    input  logic [3:0]     cycle_count,
    input  logic [2:0]     steps,
    output microcode_cycle phase,
    output logic [2:0]     step_index
);

    logic [3:0] slot;

    always_comb begin
        phase      = CYCLE_NONE;
        step_index = 3'd0;
        slot       = (cycle_count - 4'd2) >> 1;
        if (cycle_count >= 4'd2 && slot < {1'b0, steps}) begin
            phase      = cycle_count[0] ? CYCLE_REG_WRITE : CYCLE_REG_FETCH;
            step_index = slot[2:0];
        end
    end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Per-instruction cycle sequencer: fetch/latch strobes, microcode
// slots and boundary arbitration between fetch, HALT and interrupt.
module cpu_cycle_sequencer
    import cpu_cycle_sequencer_pkg::*;
#(
    parameter int MAX_STEPS = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_en,
    input  instr_length    decode_length,
    input  logic [2:0]     decode_steps,
    input  logic           halt_req,
    input  logic           irq_pending,
    input  logic           irq_enable,
    output logic           fetch_req,
    output logic           opcode_latch,
    output microcode_cycle phase,
    output logic [2:0]     step_index,
    output logic           instr_done,
    output logic           irq_ack,
    output logic           in_interrupt,
    output logic           halted,
    output logic [3:0]     cycle_count
);

    localparam logic [2:0] MAX_S = 3'(MAX_STEPS);

    seq_state   state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] len_n, len_next;
    logic [2:0] steps_s, steps_next;
    logic       halt_lat, halt_next;
    logic [3:0] len_dec;
    logic [2:0] cap, steps_cap, slot_steps;

    // Slot cap follows from the cycle budget: two setup cycles, two per slot.
    always_comb begin
        len_dec = cycle_count_int(decode_length);
        cap     = 3'((len_dec - 4'd2) >> 1);
        if (cap > MAX_S)
            cap = MAX_S;
        steps_cap = (decode_steps > cap) ? cap : decode_steps;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEQ_FETCH;
            cnt      <= 4'd0;
            len_n    <= 4'd5;
            steps_s  <= 3'd0;
            halt_lat <= 1'b0;
        end else if (clk_en) begin
            state    <= state_next;
            cnt      <= cnt_next;
            len_n    <= len_next;
            steps_s  <= steps_next;
            halt_lat <= halt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 4'd1;
        len_next     = len_n;
        steps_next   = steps_s;
        halt_next    = halt_lat;
        fetch_req    = 1'b0;
        opcode_latch = 1'b0;
        instr_done   = 1'b0;
        irq_ack      = 1'b0;
        in_interrupt = 1'b0;
        halted       = 1'b0;
        slot_steps   = 3'd0;
        unique case (state)
            SEQ_FETCH: begin
                if (cnt == 4'd0) begin
                    fetch_req = 1'b1;
                end else begin
                    opcode_latch = 1'b1;
                    len_next     = len_dec;
                    steps_next   = steps_cap;
                    halt_next    = halt_req;
                    state_next   = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                slot_steps = steps_s;
                if (cnt == len_n - 4'd1) begin
                    instr_done = 1'b1;
                    cnt_next   = 4'd0;
                    if (halt_lat)
                        state_next = SEQ_HALT;
                    else if (irq_pending && irq_enable)
                        state_next = SEQ_INTERRUPT;
                    else
                        state_next = SEQ_FETCH;
                end
            end
            SEQ_HALT: begin
                halted   = 1'b1;
                cnt_next = 4'd0;
                if (irq_pending)
                    state_next = irq_enable ? SEQ_INTERRUPT : SEQ_FETCH;
            end
            SEQ_INTERRUPT: begin
                in_interrupt = 1'b1;
                irq_ack      = (cnt == 4'd0);
                slot_steps   = INTERRUPT_STEPS;
                if (cnt == INTERRUPT_LENGTH - 4'd1) begin
                    instr_done = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = SEQ_FETCH;
                end
            end
        endcase
    end

    assign cycle_count = cnt;

    cycle_slot_decoder u_slot (
        .cycle_count (cnt),
        .steps       (slot_steps),
        .phase       (phase),
        .step_index  (step_index)
    );

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Randomized bench for cpu_cycle_sequencer against a queue-based
// model that expands each instruction into its expected cycle list.
module tb_cpu_cycle_sequencer;
    import cpu_cycle_sequencer_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           clk_en;
    instr_length    decode_length;
    logic [2:0]     decode_steps;
    logic           halt_req;
    logic           irq_pending;
    logic           irq_enable;
    logic           fetch_req;
    logic           opcode_latch;
    microcode_cycle phase;
    logic [2:0]     step_index;
    logic           instr_done;
    logic           irq_ack;
    logic           in_interrupt;
    logic           halted;
    logic [3:0]     cycle_count;

    always #5 clk = ~clk;

    cpu_cycle_sequencer #(.MAX_STEPS(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .decode_length (decode_length),
        .decode_steps  (decode_steps),
        .halt_req      (halt_req),
        .irq_pending   (irq_pending),
        .irq_enable    (irq_enable),
        .fetch_req     (fetch_req),
        .opcode_latch  (opcode_latch),
        .phase         (phase),
        .step_index    (step_index),
        .instr_done    (instr_done),
        .irq_ack       (irq_ack),
        .in_interrupt  (in_interrupt),
        .halted        (halted),
        .cycle_count   (cycle_count)
    );

    typedef struct packed {
        logic       fr;
        logic       ol;
        logic [1:0] ph;
        logic [2:0] si;
        logic       dn;
        logic       ak;
        logic       ii;
        logic       hl;
        logic [3:0] cc;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input rec_t got, input rec_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic rec_t observe();
        rec_t r;
        r.fr = fetch_req;
        r.ol = opcode_latch;
        r.ph = phase;
        r.si = step_index;
        r.dn = instr_done;
        r.ak = irq_ack;
        r.ii = in_interrupt;
        r.hl = halted;
        r.cc = cycle_count;
        return r;
    endfunction

    // Expand a sequence of n cycles with s slots into expected outputs.
    task automatic push_seq(input int n, input int s, input bit irq);
        for (int c = 0; c < n; c++) begin
            rec_t r;
            r    = '0;
            r.fr = !irq && c == 0;
            r.ol = !irq && c == 1;
            if (c >= 2 && (c - 2) / 2 < s) begin
                r.ph = (c % 2 == 0) ? CYCLE_REG_FETCH : CYCLE_REG_WRITE;
                r.si = 3'((c - 2) / 2);
            end
            r.dn = (c == n - 1);
            r.ak = irq && c == 0;
            r.ii = irq;
            r.cc = 4'(c);
            q.push_back(r);
        end
    endtask

    function automatic instr_length to_len(input int n);
        if (n == 7) return CYCLE7;
        if (n == 12) return CYCLE12;
        return CYCLE5;
    endfunction

    task automatic tick(input bit stretch, input rec_t e);
        if (stretch) begin
            repeat (3) begin
                clk_en = 1'b0;
                @(posedge clk);
                #1;
                check("hold", observe(), e);
            end
        end
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        if (stretch) clk_en = 1'b0;
    endtask

    int dlen  [4] = '{7, 12, 5, 7};
    int dstep [4] = '{2, 7, 1, 3};
    int dhalt [4] = '{0, 0, 0, 1};
    int dmode [4] = '{0, 0, 1, 2};

    initial begin
        rec_t  e;
        rec_t  h;
        string tag;
        int    next_kind, instr_no, mode, halt_ticks;
        int    cur_n, cur_s;
        bit    cur_halt, did_reset;

        for (int p = 0; p < 2; p++) begin
            reset         = 1'b1;
            clk_en        = 1'b1;
            decode_length = CYCLE5;
            decode_steps  = 3'd0;
            halt_req      = 1'b0;
            irq_pending   = 1'b0;
            irq_enable    = 1'b0;
            @(posedge clk);
            #1;
            reset      = 1'b0;
            clk_en     = (p == 1) ? 1'b0 : 1'b1;
            q.delete();
            next_kind  = 0;
            instr_no   = 0;
            mode       = 0;
            halt_ticks = 0;
            cur_n      = 5;
            cur_halt   = 1'b0;
            did_reset  = 1'b0;

            for (int t = 0; t < 700; t++) begin
                if (q.size() == 0) begin
                    case (next_kind)
                        0: begin
                            if (instr_no < 4) begin
                                cur_n    = dlen[instr_no];
                                cur_s    = dstep[instr_no];
                                cur_halt = dhalt[instr_no] != 0;
                                mode     = dmode[instr_no];
                            end else begin
                                case ($urandom_range(0, 2))
                                    0:       cur_n = 5;
                                    1:       cur_n = 7;
                                    default: cur_n = 12;
                                endcase
                                cur_s    = $urandom_range(0, 7);
                                cur_halt = $urandom_range(0, 7) == 0;
                                mode     = 3;
                            end
                            decode_length = to_len(cur_n);
                            decode_steps  = 3'(cur_s);
                            halt_req      = cur_halt;
                            if (cur_s > (cur_n - 2) / 2)
                                cur_s = (cur_n - 2) / 2;
                            push_seq(cur_n, cur_s, 1'b0);
                            instr_no++;
                        end
                        1: begin
                            h    = '0;
                            h.hl = 1'b1;
                            q.push_back(h);
                        end
                        default: push_seq(12, 3, 1'b1);
                    endcase
                end

                case (mode)
                    0: begin
                        irq_pending = 1'b0;
                        irq_enable  = 1'($urandom_range(0, 1));
                    end
                    1: begin
                        irq_pending = 1'b1;
                        irq_enable  = 1'b1;
                    end
                    2: begin
                        irq_enable  = 1'b0;
                        irq_pending = halt_ticks >= 19;
                    end
                    default: begin
                        irq_pending = $urandom_range(0, 7) == 0;
                        irq_enable  = 1'($urandom_range(0, 1));
                    end
                endcase

                e   = q.pop_front();
                tag = e.ii ? "irq" : (e.hl ? "halt" : "instr");
                check(tag, observe(), e);

                if (q.size() == 0) begin
                    if (e.hl) begin
                        halt_ticks++;
                        next_kind = irq_pending ? (irq_enable ? 2 : 0) : 1;
                    end else if (e.ii) begin
                        next_kind = 0;
                    end else if (cur_halt) begin
                        next_kind  = 1;
                        halt_ticks = 0;
                    end else begin
                        next_kind = (irq_pending && irq_enable) ? 2 : 0;
                    end
                end

                if (!did_reset && mode == 3 && !e.ii && !e.hl &&
                    cur_n == 12 && e.cc == 4'd5) begin
                    did_reset = 1'b1;
                    reset     = 1'b1;
                    @(posedge clk);
                    #1;
                    reset     = 1'b0;
                    q.delete();
                    next_kind = 0;
                    continue;
                end

                tick(p == 1, e);

                if (e.ol) begin
                    decode_length = instr_length'($urandom_range(0, 3));
                    decode_steps  = 3'($urandom_range(0, 7));
                    halt_req      = 1'($urandom_range(0, 1));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
